// File: rtl/sevenseg_scan_driver_if.sv
// sevenseg_scan_driver_if: scan-step, digit data and display pin bundle for the seven-segment scan driver
interface sevenseg_scan_driver_if;
  logic        scan_clk;
  logic        hold;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [1:0]  digit_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  modport master (
    output scan_clk, hold, digits, dp_mask, blank_lz,
    input  digit_sel, an, seg, dp
  );
  modport slave (
    input  scan_clk, hold, digits, dp_mask, blank_lz,
    output digit_sel, an, seg, dp
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: 4-digit common-anode seven-segment scan driven by rising edges of a slow divider clock
module sevenseg_scan_driver #(
  parameter bit SYNC_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  sevenseg_scan_driver_if.slave bus
);
  logic [1:0] sync;
  logic       prev;
  logic       sig;
  logic       tick;
  logic [1:0] idx;
  logic [3:0] nib;
  logic       z3, z2, z1;
  logic       blank;
  logic [6:0] dec;
  logic [1:0] digit_sel_q;
  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;
  assign sig  = SYNC_EN ? sync[1] : bus.scan_clk;
  assign tick = sig & ~prev;
  assign nib  = bus.digits[{idx, 2'b00} +: 4];
  // each zero flag means "this digit and every digit to its left are zero"
  assign z3    = bus.digits[15:12] == 4'h0;
  assign z2    = z3 & (bus.digits[11:8] == 4'h0);
  assign z1    = z2 & (bus.digits[7:4] == 4'h0);
  assign blank = bus.blank_lz & (idx == 2'd3 ? z3 : idx == 2'd2 ? z2 : idx == 2'd1 ? z1 : 1'b0);
  always_comb begin
    dec = 7'h7F;
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
      default: dec = 7'h7F;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync        <= 2'b00;
      prev        <= 1'b0;
      idx         <= 2'd0;
      digit_sel_q <= 2'd0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      sync        <= {sync[0], bus.scan_clk};
      prev        <= sig;
      idx         <= (tick && !bus.hold) ? idx + 2'd1 : idx;
      digit_sel_q <= idx;
      an_q        <= ~(4'b0001 << idx);
      seg_q       <= blank ? 7'h7F : dec;
      dp_q        <= ~bus.dp_mask[idx];
    end
  end
  assign bus.digit_sel = digit_sel_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Consumer end of the stopwatch slow-clock path. Takes the divided clock level from the clock divider and detects its rising edges in the fast `clk` domain.
- On each rising edge it advances a 4-digit time-multiplex scan.
- It drives the active-low anode, segment and decimal-point pins of a 4-digit common-anode seven-segment display from four packed hex/BCD nibbles.
- Supports optional leading-zero blanking.

Parameters:
- SYNC_EN, 1: 1 = pass scan_clk through 2-flop synchronizer before edge detect; 0 = scan_clk is already clk-domain (driven directly by the divider register), no synchronizer.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- scan_clk  input  1  slow clock level from divider; each rising edge = one scan step.
- hold  input  1  when high, scan edges are ignored (digit index frozen).
- digits  input  16  digit3=[15:12] (leftmost) .. digit0=[3:0] (rightmost).
- dp_mask  input  4  bit i high = light decimal point of digit i.
- blank_lz  input  1  enable leading-zero blanking.
- digit_sel  output  2  current scan index (registered).
- an  output  4  anode enables, active low, an[i] = digit i.
- seg  output  7  segments, active low, seg[6:0] = g,f,e,d,c,b,a.
- dp  output  1  decimal point, active low.

Behaviour:
- Reset state (registered outputs):
  - All internal flops cleared: sync stages = 0, edge-history flop = 0, idx = 0.
  - Outputs: an = 4'b1111 (all off), seg = 7'h7F, dp = 1, digit_sel = 0.
- Edge detect:
  - sig = second synchronizer stage (SYNC_EN=1) or scan_clk (SYNC_EN=0).
  - prev <= sig every cycle.
  - tick = sig & ~prev; one clk cycle per scan_clk rising edge, regardless of scan_clk high time.
  - scan_clk held high or low produces no further ticks.
  - Falling edges are ignored.
- Index:
  - On a clk edge with tick=1 and hold=0: idx <= idx + 1, 2-bit wrap 3 -> 0.
  - tick with hold=1 is dropped, not deferred.
- Output register, updated every cycle from current idx and current inputs (1-cycle latency):
  - digit_sel <= idx.
  - an <= ~(4'b0001 << idx).
  - seg <= decode(nibble[idx]), or 7'h7F if blanked.
  - dp <= ~dp_mask[idx].
- Latency, scan_clk first sampled high at clk edge N:
  - SYNC_EN=1: idx changes at edge N+2; an/seg change at edge N+3.
  - SYNC_EN=0: idx changes at edge N; an/seg change at edge N+1.
- Decode (active-low, g..a), hex 0-F:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (blank_lz=1):
  - digit3 blanked if digit3 == 0.
  - digit2 blanked if digit3 == digit2 == 0.
  - digit1 blanked if digits 3..1 are all 0.
  - digit0 never blanked.
  - A blanked digit still has its anode asserted; seg = 7'h7F; dp still follows dp_mask.
- Input changes: digits, dp_mask and blank_lz changes take effect on the next clk edge, with no tick required.
- Reset mid-scan: the next edge forces the reset state. The first post-reset output (edge after reset deasserts) shows digit0 with an = 1110. A scan_clk already high at reset release with prev=0 yields one tick, which is legal.
- Exactly one anode is low at all times after the first post-reset cycle.

Test Plan:
- Reset then idle, digits=16'h1234, scan_clk=0 -> after reset release: an=1110, seg=7'h19 ('4'), dp=1, digit_sel=0, stable indefinitely.
- SYNC_EN=1, four scan_clk pulses 8 clk high / 8 clk low, digits=16'h1234 ->
  - each rise: an steps 1101/1011/0111/1110, seg steps 30/24/79/19;
  - each update lands exactly 3 clk after the first high sample;
  - one step per pulse.
- scan_clk held high 100 cycles -> exactly one idx increment. hold=1 during a rise -> no increment; index resumes on the next rise after hold=0.
- blank_lz=1, digits=16'h0070 ->
  - digit3 and digit2: seg=7F (anode still cycles);
  - digit1: seg=78 ('7'); digit0: seg=40.
  - With digits=16'h0000, only digit0 shows 40.
- dp_mask=4'b0100, digits=16'hABCD -> dp=0 only while an=1011. Across the full 0-F sweep, seg matches the decode list above.
- Reset asserted while idx=2 -> next edge: an=1111, seg=7F, digit_sel=0. First cycle after release: an=1110.
